// File: rtl/mask_pkg.sv
// Shared types and default widths for the masking encoder and the DOM gadgets it feeds.
package mask_pkg;

  localparam int DEFAULT_W  = 8;
  localparam int DEFAULT_CW = 16;

  typedef struct packed {
    logic [DEFAULT_W-1:0] a;
    logic [DEFAULT_W-1:0] b;
  } share_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RND = 1'b1
  } gen_state_e;

endpackage

// File: rtl/mask_share_gen_if.sv
// Plaintext, randomness and share-pair handshakes of the masking encoder.
interface mask_share_gen_if #(
  parameter int W = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [W-1:0] rnd_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;

  // The encoder is the master: it drives the ready signals and the share pair
  modport master (
    input  in_valid, in_data, rnd_valid, rnd_data, out_ready,
    output in_ready, rnd_ready, out_valid, out_a, out_b
  );

  modport slave (
    output in_valid, in_data, rnd_valid, rnd_data, out_ready,
    input  in_ready, rnd_ready, out_valid, out_a, out_b
  );

endinterface

// File: rtl/mask_share_gen.sv
// Two-share masking encoder: out_a = d ^ r, out_b = r, with one fresh random word per plaintext word.
module mask_share_gen
  import mask_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int CW           = DEFAULT_CW,
  parameter bit ZERO_ON_IDLE = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  mask_share_gen_if.master    bus,
  input  logic                clr_cnt,
  output logic [CW-1:0]       starve_cnt
);

  gen_state_e    state_q;
  logic [W-1:0]  data_q;
  logic          outValid_q;
  logic [W-1:0]  outA_q;
  logic [W-1:0]  outB_q;
  logic [CW-1:0] starveCnt_q;
  logic [CW-1:0] starveCnt_d;

  logic inReady;
  logic rndReady;
  logic inFire;
  logic starving;

  // Accepting a new word requires the out slot to be free or draining this cycle
  always_comb begin
    inReady  = 1'b0;
    rndReady = 1'b1;
    if (state_q == IDLE) begin
      inReady  = !outValid_q || bus.out_ready;
      rndReady = bus.in_valid && inReady;
    end
  end

  assign inFire   = bus.in_valid && inReady;
  assign starving = (state_q == WAIT_RND) && !bus.rnd_valid;

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (clr_cnt) begin
      starveCnt_d = '0;
    end else if (starving && (starveCnt_q != '1)) begin
      starveCnt_d = starveCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      data_q      <= '0;
      outValid_q  <= 1'b0;
      outA_q      <= '0;
      outB_q      <= '0;
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;

      if (outValid_q && bus.out_ready) begin
        outValid_q <= 1'b0;
        if (ZERO_ON_IDLE) begin
          outA_q <= '0;
          outB_q <= '0;
        end
      end

      // A load below overrides the drain above, keeping back-to-back throughput
      case (state_q)
        IDLE: begin
          if (inFire) begin
            if (bus.rnd_valid) begin
              outA_q     <= bus.in_data ^ bus.rnd_data;
              outB_q     <= bus.rnd_data;
              outValid_q <= 1'b1;
            end else begin
              data_q  <= bus.in_data;
              state_q <= WAIT_RND;
            end
          end
        end
        WAIT_RND: begin
          if (bus.rnd_valid) begin
            outA_q     <= data_q ^ bus.rnd_data;
            outB_q     <= bus.rnd_data;
            outValid_q <= 1'b1;
            state_q    <= IDLE;
            if (ZERO_ON_IDLE) begin
              data_q <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.rnd_ready = rndReady;
  assign bus.out_valid = outValid_q;
  assign bus.out_a     = outA_q;
  assign bus.out_b     = outB_q;
  assign starve_cnt    = starveCnt_q;

endmodule

// File: tb/tb_mask_share_gen.sv
// Directed self-checking bench for mask_share_gen: streaming, starvation, backpressure, saturation and reset.
module tb_mask_share_gen;
  import mask_pkg::*;

  logic        clk;
  logic        rstn;
  logic        clrCnt;
  logic [15:0] starveCnt;
  logic        satClr;
  logic [1:0]  satCnt;

  int total;
  int bad;

  mask_share_gen_if #(.W(8)) bus ();
  mask_share_gen_if #(.W(8)) satBus ();

  mask_share_gen #(.W(8), .CW(16), .ZERO_ON_IDLE(1'b1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.master),
    .clr_cnt    (clrCnt),
    .starve_cnt (starveCnt)
  );

  mask_share_gen #(.W(8), .CW(2), .ZERO_ON_IDLE(1'b1)) dutSat (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (satBus.master),
    .clr_cnt    (satClr),
    .starve_cnt (satCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic rv,
                               input logic [7:0] rd, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.rnd_valid = rv;
    bus.rnd_data  = rd;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wordD [4];
  logic [7:0] wordR [4];

  initial begin
    total = 0;
    bad   = 0;
    wordD[0] = 8'hA5; wordR[0] = 8'h3C;
    wordD[1] = 8'h12; wordR[1] = 8'h34;
    wordD[2] = 8'hC3; wordR[2] = 8'h5A;
    wordD[3] = 8'h80; wordR[3] = 8'h01;

    rstn   = 1'b0;
    clrCnt = 1'b0;
    satClr = 1'b0;
    satBus.in_valid  = 1'b0;
    satBus.in_data   = 8'h00;
    satBus.rnd_valid = 1'b0;
    satBus.rnd_data  = 8'h00;
    satBus.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    tick();

    // Reset state
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_a", 32'(bus.out_a), 32'h00);
    checkOutput("rst_out_b", 32'(bus.out_b), 32'h00);
    checkOutput("rst_starve", 32'(starveCnt), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream of four words, one per cycle
    rstn = 1'b1;
    applyStimulus(1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1);
    checkOutput("b2b_rnd_ready", 32'(bus.rnd_ready), 32'd1);
    tick();
    checkOutput("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("b2b_first_a", 32'(bus.out_a), 32'h99);
    checkOutput("b2b_first_b", 32'(bus.out_b), 32'h3C);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b1, wordD[i], 1'b1, wordR[i], 1'b1);
      checkOutput("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      checkOutput("b2b_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("b2b_a", 32'(bus.out_a), 32'(wordD[i] ^ wordR[i]));
      checkOutput("b2b_b", 32'(bus.out_b), 32'(wordR[i]));
      checkOutput("b2b_unmask", 32'(bus.out_a ^ bus.out_b), 32'(wordD[i]));
    end
    checkOutput("b2b_last_a", 32'(bus.out_a), 32'h81);

    // Last pair drains with nothing new: shares are zeroed
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_a_zero", 32'(bus.out_a), 32'h00);
    checkOutput("idle_b_zero", 32'(bus.out_b), 32'h00);

    // RNG starvation for five cycles
    applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("starve_state", 32'(dut.state_q), 32'(WAIT_RND));
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("starve_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("starve_rnd_ready", 32'(bus.rnd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("starve_wait_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("starve_count_step", 32'(starveCnt), 32'(i + 1));
    end
    checkOutput("starve_cnt5", 32'(starveCnt), 32'd5);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hF0, 1'b1);
    tick();
    checkOutput("starve_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("starve_out_a", 32'(bus.out_a), 32'hFF);
    checkOutput("starve_out_b", 32'(bus.out_b), 32'hF0);
    checkOutput("starve_cnt_hold", 32'(starveCnt), 32'd5);
    checkOutput("starve_data_cleared", 32'(dut.data_q), 32'h00);
    checkOutput("starve_back_idle", 32'(dut.state_q), 32'(IDLE));

    // Backpressure: pair held stable for three cycles
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h11, 1'b0);
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_rnd_ready", 32'(bus.rnd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_a_stable", 32'(bus.out_a), 32'hFF);
      checkOutput("bp_b_stable", 32'(bus.out_b), 32'hF0);
      checkOutput("bp_in_ready_hold", 32'(bus.in_ready), 32'd0);
    end
    applyStimulus(1'b1, 8'h77, 1'b1, 8'h11, 1'b1);
    checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("bp_new_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("bp_new_a", 32'(bus.out_a), 32'h66);
    checkOutput("bp_new_b", 32'(bus.out_b), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("bp_drain_valid", 32'(bus.out_valid), 32'd0);

    // Clear beats increment while starving
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    clrCnt = 1'b1;
    tick();
    checkOutput("clr_priority", 32'(starveCnt), 32'd0);
    clrCnt = 1'b0;
    tick();
    checkOutput("clr_then_count", 32'(starveCnt), 32'd1);

    // Reset while holding 0x55 in WAIT_RND
    rstn = 1'b0;
    tick();
    checkOutput("midrst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_starve", 32'(starveCnt), 32'd0);
    rstn = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hAA, 1'b1);
    checkOutput("midrst_rnd_not_taken", 32'(bus.rnd_ready), 32'd0);
    tick();
    checkOutput("midrst_no_replay", 32'(bus.out_valid), 32'd0);
    applyStimulus(1'b1, 8'h3C, 1'b1, 8'hAA, 1'b1);
    tick();
    checkOutput("midrst_fresh_a", 32'(bus.out_a), 32'h96);
    checkOutput("midrst_fresh_b", 32'(bus.out_b), 32'hAA);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Narrow counter saturates at 3
    satBus.in_valid = 1'b1;
    satBus.in_data  = 8'h0F;
    tick();
    satBus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("sat_count", 32'(satCnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    satClr = 1'b1;
    tick();
    checkOutput("sat_clr_priority", 32'(satCnt), 32'd0);
    satClr = 1'b0;
    satBus.rnd_valid = 1'b1;
    satBus.rnd_data  = 8'hF0;
    tick();
    checkOutput("sat_exit_a", 32'(satBus.out_a), 32'hFF);
    satBus.rnd_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
